// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with a HI/LO register pair and direct HI/LO writes.
// Define MDU_DIV_EN to build the divider; without it div/divu are treated as no-ops.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        fsm_state
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [63:0]     res;
    logic            skip_wr;

    // Products are formed from the live operands and latched on the accept edge.
    logic signed [63:0] sa64, sb64, prod_s;
    logic        [63:0] prod_u;

    assign sa64   = {{32{A[31]}}, A};
    assign sb64   = {{32{B[31]}}, B};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, A} * {32'd0, B};

    logic        is_mul, is_div, div_zero;
    logic [63:0] div_res;

    assign is_mul = (MDUop == OP_MULT) || (MDUop == OP_MULTU);

`ifdef MDU_DIV_EN
    logic               ovf;
    logic [31:0]        dvs_safe;
    logic signed [31:0] sq, sr;
    logic        [31:0] uq, ur;

    // A zero divisor or the INT_MIN/-1 case is replaced by 1: the zero case
    // never writes back, and INT_MIN/1 yields exactly the defined overflow result.
    assign ovf      = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign dvs_safe = ((B == 32'd0) || ovf) ? 32'd1 : B;
    assign sq       = $signed(A) / $signed(dvs_safe);
    assign sr       = $signed(A) % $signed(dvs_safe);
    assign uq       = A / dvs_safe;
    assign ur       = A % dvs_safe;

    assign is_div   = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
    assign div_zero = (B == 32'd0);
    assign div_res  = (MDUop == OP_DIV) ? {sr, sq} : {ur, uq};
`else
    assign is_div   = 1'b0;
    assign div_zero = 1'b0;
    assign div_res  = 64'd0;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            res     <= '0;
            skip_wr <= 1'b0;
            Busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (is_mul) begin
                            res     <= (MDUop == OP_MULT) ? prod_s : prod_u;
                            skip_wr <= 1'b0;
                            cnt     <= CW'(MULT_CYCLES);
                            Busy    <= 1'b1;
                            state   <= RUN;
                        end else if (is_div) begin
                            res     <= div_res;
                            skip_wr <= div_zero;
                            cnt     <= CW'(DIV_CYCLES);
                            Busy    <= 1'b1;
                            state   <= RUN;
                        end else if (MDUop == OP_MTHI) begin
                            HI <= A;
                        end else if (MDUop == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                        if (!skip_wr) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: drivers push expected HI/LO/Busy-length into a queue,
// a negedge monitor pops and compares when Busy falls or a zero-stall op is sampled.
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUop;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;
    logic        fsm_state;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUop(MDUop), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: {busy_len[31:0], hi[31:0], lo[31:0]}
    logic [95:0] exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        sample_now = 1'b0;

    task automatic expect_res(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_q.push_back({32'(len), hi, lo});
        name_q.push_back(nm);
    endtask

    task automatic op_cycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUop = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; MDUop = OP_NONE;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Busy === 1'b1 && n < 100);
        if (Busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required busy=0", nm, Busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic long_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input int len);
        expect_res(nm, hi, lo, len);
        op_cycle(op, a, b);
        wait_idle(nm);
    endtask

    task automatic short_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo);
        expect_res(nm, hi, lo, 0);
        op_cycle(op, a, b);
        sample_now = 1'b1;
        @(posedge clk); #1;
        sample_now = 1'b0;
    endtask

    // Monitor
    logic        busy_prev = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] hold_hi, hold_lo;
    logic        hold_bad = 1'b0;

    task automatic check_pop(input int act_len, input logic bad);
        logic [95:0] e;
        string       nm;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: hi=%h lo=%h busy_cycles=%0d, required no output", HI, LO, act_len);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (HI !== e[63:32] || LO !== e[31:0] || 32'(act_len) !== e[95:64] || bad) begin
                miscompares++;
                $display("FAIL %s: got hi=%h lo=%h busy_cycles=%0d hold_broken=%0d, required hi=%h lo=%h busy_cycles=%0d hold_broken=0",
                         nm, HI, LO, act_len, bad, e[63:32], e[31:0], e[95:64]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sample_now) begin
            check_pop((Busy === 1'b0) ? 0 : 1, 1'b0);
        end else if (busy_prev && Busy === 1'b0) begin
            check_pop(busy_cnt, hold_bad);
            busy_cnt = 0;
        end
        if (Busy === 1'b1) begin
            if (!busy_prev) begin
                busy_cnt = 1;
                hold_hi  = HI;
                hold_lo  = LO;
                hold_bad = 1'b0;
            end else begin
                busy_cnt++;
                if (HI !== hold_hi || LO !== hold_lo) hold_bad = 1'b1;
            end
        end
        busy_prev = (Busy === 1'b1);
    end

    initial begin
        reset = 1'b0; Start = 1'b0; MDUop = OP_NONE; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_res("reset_state", 32'h0, 32'h0, 0);
        sample_now = 1'b1;
        @(posedge clk); #1;
        sample_now = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        long_op("mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
        long_op("multu_fffex3",  OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULT_N);
        long_op("mult_maxpos_sq", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULT_N);
        long_op("mult_intmin_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N);
        long_op("multu_max_sq",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N);

        // mthi then mtlo on consecutive edges
        expect_res("mthi", 32'h1234_5678, 32'h0000_0001, 0);
        op_cycle(OP_MTHI, 32'h1234_5678, 32'd0);
        sample_now = 1'b1;
        expect_res("mtlo", 32'h1234_5678, 32'h9ABC_DEF0, 0);
        op_cycle(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        @(posedge clk); #1;
        sample_now = 1'b0;

`ifdef MDU_DIV_EN
        long_op("div_by_zero",  OP_DIV,  32'd5, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, DIV_N);
        long_op("div_neg7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
        long_op("divu_7_2",     OP_DIVU, 32'd7, 32'd2, 32'h0000_0001, 32'h0000_0003, DIV_N);
        long_op("div_10_3",     OP_DIV,  32'd10, 32'd3, 32'h0000_0001, 32'h0000_0003, DIV_N);
        long_op("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N);
        long_op("divu_by_zero", OP_DIVU, 32'd9, 32'd0, 32'h0000_0000, 32'h8000_0000, DIV_N);
`else
        short_op("div_by_zero_off", OP_DIV,  32'd5, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        short_op("div_10_3_off",    OP_DIV,  32'd10, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        short_op("divu_7_2_off",    OP_DIVU, 32'd7, 32'd2, 32'h1234_5678, 32'h9ABC_DEF0);
`endif
        short_op("reserved_op", 3'b111, 32'hFFFF_FFFF, 32'd1, HI, LO);

        // mtlo pulsed during RUN must be ignored
        expect_res("mult_ignore_mtlo", 32'h0, 32'h0001_2340, MULT_N);
        op_cycle(OP_MULT, 32'h0000_1234, 32'h0000_0010);
        op_cycle(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        wait_idle("mult_ignore_mtlo");

        // reset on cycle 4 of RUN abandons the op
        expect_res("reset_abort", 32'h0, 32'h0, 4);
`ifdef MDU_DIV_EN
        op_cycle(OP_DIV, 32'd100, 32'd7);
`else
        op_cycle(OP_MULT, 32'd100, 32'd7);
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        long_op("mult_1x1_after_reset", OP_MULT, 32'd1, 32'd1, 32'h0, 32'h1, MULT_N);

        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations: %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the execute stage, fed by the same register-file operands as the ALU, with the same A/B operand convention. It performs signed and unsigned 32×32 multiply and divide into a HI/LO register pair and supports direct HI/LO writes. It asserts `Busy` while an operation is in flight, and the pipeline controller stalls on it. It never writes the register file itself; downstream reads of HI/LO go through the `HI`/`LO` outputs.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for `mult`/`multu` (legal ≥1).
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for `div`/`divu` (legal ≥1).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `Start` input 1: operation request, sampled on the rising edge.
- `MDUop` input 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- `A` input 32: operand 1 (multiplicand / dividend / mthi-mtlo source).
- `B` input 32: operand 2 (multiplier / divisor).
- `Busy` output 1: operation in progress.
- `HI` output 32: HI register (product high word / remainder).
- `LO` output 32: LO register (product low word / quotient).

## Operation
- States: IDLE, RUN. Internal state: down-counter, latched op, latched 64-bit result.
- IDLE + `Start` + mult/multu/div/divu: compute and latch the result from `A`/`B` at the accept edge. Load the counter with `MULT_CYCLES` or `DIV_CYCLES`, then go to RUN.
- RUN: decrement each cycle. On the edge where the counter expires, write `HI`/`LO` from the latched result and return to IDLE.
- IDLE + `Start` + mthi/mtlo: write `HI`/`LO` = `A` on that edge. Stay IDLE; `Busy` is never raised.
- IDLE + `Start` + none/reserved: no effect.
- `Start` while RUN: ignored entirely, including mthi/mtlo. The controller must not issue while `Busy`.
- Arithmetic:
  - mult: `{HI,LO}` = signed(A)×signed(B), 64-bit.
  - multu: the same product with both operands unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO/HI = unsigned quotient/remainder.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div or divu, B=0): the op is accepted and `Busy` runs the full `DIV_CYCLES`, but `HI`/`LO` are left unchanged at completion.
- Reset low: `HI`=0, `LO`=0, `Busy`=0, counter=0, state IDLE. Reset during RUN abandons the op with no HI/LO update. Reset has priority over `Start`.

## Timing
- Outputs are registered; no combinational path from `Start`/`A`/`B` to any output.
- Accept edge k: `Busy`=1 from after edge k through edge k+N, where N = cycle parameter.
- At edge k+N: `HI`/`LO` take the new values and `Busy` falls to 0. New values are visible in the same cycle `Busy` is low.
- `HI`/`LO` hold their old values for the whole of RUN.
- A new op may be accepted on edge k+N+1 at the earliest, i.e. when `Start` is seen with `Busy`=0. Back-to-back ops are spaced N+1 edges apart.
- mthi/mtlo: visible one cycle after the accept edge; zero stall.

## Configuration
- `MDU_DIV_EN` defined: div/divu are implemented as above.
- `MDU_DIV_EN` undefined:
  - no divider logic is built;
  - `MDUop` 011/100 behave as none (`Busy` stays 0, HI/LO unchanged);
  - `DIV_CYCLES` is unused.

## Test plan
- After reset, `Start`,mult with A=0xFFFFFFFE (−2), B=3 → `Busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div with A=0xFFFFFFF9 (−7), B=2 → after 10 `Busy` cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO update one cycle each, `Busy` never asserts. Then div with B=0 → 10 `Busy` cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- Start mult, then pulse mtlo A=0xDEADBEEF on cycle 2 of RUN → the mtlo is ignored and the final LO is the product low word.
- Start div, drive reset low on cycle 4 → next edge `Busy`=0, HI=LO=0. Releasing reset and starting mult 1×1 gives LO=1 after 5 cycles.
- With `MDU_DIV_EN` undefined, `Start`,div with A=10, B=3 → `Busy` stays 0, HI/LO unchanged. With it defined, div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
